// File: rtl/mux_rr_sequencer_pkg.sv
// Shared constants and FSM state type for the round-robin mux sequencer.
package mux_rr_pkg;

   localparam int unsigned N_SRC = 16;
   localparam int unsigned SEL_W = 4;

   // Bit positions of the selector controls inside mux_sel.
   localparam int unsigned SEL_Q = 3;
   localparam int unsigned SEL_R = 2;
   localparam int unsigned SEL_S = 1;
   localparam int unsigned SEL_T = 0;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE
   } state_t;

endpackage

// File: rtl/mux_rr_sequencer_rr_pick16.sv
// Rotating priority encoder: first set request strictly after rr_ptr, wrapping mod 16.
module rr_pick16
   import mux_rr_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Offset N_SRC wraps back to rr_ptr itself, so the last winner has lowest priority.
      for (int unsigned i = 1; i <= N_SRC; i++) begin
         cand = rr_ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer sharing one 16:1 selector among 16 requesters.
// Optional MUX_RR_SEQUENCER_LOCK_EN adds a `lock` input that keeps the current grant sampling.
module mux_rr_sequencer
   import mux_rr_pkg::*;
#(
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req,
   output logic [SEL_W-1:0] mux_sel,
   output logic             mux_en,
   input  logic             mux_out,
   output logic [N_SRC-1:0] gnt,
   output logic             busy,
   output logic             smp_valid,
   output logic             smp_data,
   output logic [SEL_W-1:0] smp_src
`ifdef MUX_RR_SEQUENCER_LOCK_EN
   ,
   input  logic             lock
`endif
);

   if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_hold_chk
      $error("mux_rr_sequencer: HOLD_CYC must be in 1..15");
   end

   localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYC - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             en_q, en_d;
   logic [N_SRC-1:0] gnt_q, gnt_d;
   logic             vld_q, vld_d;
   logic             data_q, data_d;
   logic [SEL_W-1:0] src_q, src_d;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic             relock;

   rr_pick16 u_pick (
      .req    (req),
      .rr_ptr (ptr_q),
      .idx    (pick_idx),
      .found  (pick_found)
   );

`ifdef MUX_RR_SEQUENCER_LOCK_EN
   assign relock = lock & req[sel_q];
`else
   assign relock = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      en_d    = en_q;
      gnt_d   = gnt_q;
      vld_d   = 1'b0;
      data_d  = data_q;
      src_d   = src_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d   = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
               sel_d   = pick_idx;
               en_d    = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = SAMPLE;
            else             cnt_d   = cnt_q - 4'd1;
         end
         SAMPLE: begin
            vld_d  = 1'b1;
            data_d = mux_out;
            src_d  = sel_q;
            // A locked grant re-enters SETTLE without touching rr_ptr or the selector.
            if (relock) begin
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end else begin
               ptr_d   = sel_q;
               gnt_d   = '0;
               en_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '1;
         sel_q   <= '0;
         en_q    <= 1'b0;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         data_q  <= 1'b0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign mux_sel   = {sel_q[SEL_Q], sel_q[SEL_R], sel_q[SEL_S], sel_q[SEL_T]};
   assign mux_en    = en_q;
   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign smp_valid = vld_q;
   assign smp_data  = data_q;
   assign smp_src   = src_q;

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Self-checking bench for mux_rr_sequencer; the lock scenario runs when MUX_RR_SEQUENCER_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_mux_rr_sequencer;

   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic [15:0] pattern = '0;
   logic [3:0]  mux_sel, smp_src;
   logic        mux_en, mux_out, busy, smp_valid, smp_data;
   logic [15:0] gnt;
`ifdef MUX_RR_SEQUENCER_LOCK_EN
   logic        lock = 1'b0;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   // Behavioural 16:1 selector with enable.
   assign mux_out = mux_en & pattern[mux_sel];

   mux_rr_sequencer #(.HOLD_CYC(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mux_sel   (mux_sel),
      .mux_en    (mux_en),
      .mux_out   (mux_out),
      .gnt       (gnt),
      .busy      (busy),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .smp_src   (smp_src)
`ifdef MUX_RR_SEQUENCER_LOCK_EN
      ,
      .lock      (lock)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int waited, output bit seen);
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < limit) begin
         tick();
         waited++;
         if (smp_valid === 1'b1) seen = 1'b1;
      end
   endtask

   // Reference arbitration: first requester after ptr going upward modulo 16.
   function automatic int ref_pick(input logic [15:0] r, input int ptr);
      for (int k = 1; k <= 16; k++)
         if (r[(ptr + k) % 16]) return (ptr + k) % 16;
      return -1;
   endfunction

   task automatic test_reset;
      req = '0;
      pattern = 16'($urandom);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      compared++;
      if ({gnt, mux_sel, mux_en, busy, smp_valid, smp_data, smp_src} !== 29'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: gnt=%h sel=%h en=%b busy=%b vld=%b data=%b src=%h, want all 0",
                  gnt, mux_sel, mux_en, busy, smp_valid, smp_data, smp_src);
      end
   endtask

   task automatic test_single;
      req = 16'h0001;
      for (int c = 1; c <= 6; c++) begin
         tick();
         compared++;
         if (mux_en !== (c >= 1 && c <= 3) || smp_valid !== (c == 4)) begin
            mismatched++;
            $display("FAIL single_timing c=%0d: en=%b vld=%b, want en=%b vld=%b",
                     c, mux_en, smp_valid, (c >= 1 && c <= 3), (c == 4));
         end
         if (c <= 3) begin
            compared++;
            if (gnt !== 16'h0001 || mux_sel !== 4'd0 || busy !== 1'b1) begin
               mismatched++;
               $display("FAIL single_grant c=%0d: gnt=%h sel=%h busy=%b, want 0001 0 1", c, gnt, mux_sel, busy);
            end
         end
         if (c == 4) begin
            compared++;
            if (smp_src !== 4'd0 || smp_data !== pattern[0] || gnt !== 16'h0 || busy !== 1'b0) begin
               mismatched++;
               $display("FAIL single_sample: src=%0d data=%b gnt=%h busy=%b, want 0 %b 0000 0",
                        smp_src, smp_data, gnt, busy, pattern[0]);
            end
            req = '0;
         end
      end
   endtask

   task automatic test_full_load;
      int w;
      bit s;
      do_reset();
      pattern = 16'($urandom);
      req = 16'hFFFF;
      for (int n = 0; n < 17; n++) begin
         wait_valid(12, w, s);
         compared++;
         if (!s || w != HOLD + 2 || smp_src !== 4'(n % 16) || smp_data !== pattern[n % 16]) begin
            mismatched++;
            $display("FAIL full_load n=%0d: seen=%b gap=%0d src=%0d data=%b, want gap=%0d src=%0d data=%b",
                     n, s, w, smp_src, smp_data, HOLD + 2, n % 16, pattern[n % 16]);
         end
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_wrap;
      int w;
      bit s;
      do_reset();
      req = 16'h0020;
      wait_valid(12, w, s);
      compared++;
      if (!s || smp_src !== 4'd5) begin
         mismatched++;
         $display("FAIL wrap_setup: seen=%b src=%0d, want src=5", s, smp_src);
      end
      req = 16'h0011;
      wait_valid(12, w, s);
      compared++;
      if (!s || w != HOLD + 2 || smp_src !== 4'd0) begin
         mismatched++;
         $display("FAIL wrap_first: seen=%b gap=%0d src=%0d, want gap=%0d src=0", s, w, smp_src, HOLD + 2);
      end
      req = 16'h0010;
      wait_valid(12, w, s);
      compared++;
      if (!s || w != HOLD + 2 || smp_src !== 4'd4) begin
         mismatched++;
         $display("FAIL wrap_second: seen=%b gap=%0d src=%0d, want gap=%0d src=4", s, w, smp_src, HOLD + 2);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_req_drop;
      pattern = 16'($urandom) | 16'h0400;
      req = 16'h0400;
      tick();
      tick();
      req = '0;
      tick();
      compared++;
      if (smp_valid !== 1'b0 || mux_en !== 1'b1 || mux_sel !== 4'd10) begin
         mismatched++;
         $display("FAIL drop_midway: vld=%b en=%b sel=%0d, want 0 1 10", smp_valid, mux_en, mux_sel);
      end
      tick();
      compared++;
      if (smp_valid !== 1'b1 || smp_src !== 4'd10 || smp_data !== 1'b1) begin
         mismatched++;
         $display("FAIL drop_sample: vld=%b src=%0d data=%b, want 1 10 1", smp_valid, smp_src, smp_data);
      end
      tick();
      compared++;
      if (smp_valid !== 1'b0 || busy !== 1'b0 || mux_sel !== 4'd10) begin
         mismatched++;
         $display("FAIL drop_after: vld=%b busy=%b sel=%0d, want 0 0 10 (sel held)", smp_valid, busy, mux_sel);
      end
   endtask

   task automatic test_reset_mid;
      int w;
      bit s;
      req = 16'h0008;
      wait_valid(12, w, s);
      req = '0;
      tick();
      tick();
      req = 16'h0011;
      tick();
      compared++;
      if (busy !== 1'b1 || smp_src !== 4'd3) begin
         mismatched++;
         $display("FAIL rstmid_pre: busy=%b src=%0d, want 1 3", busy, smp_src);
      end
      rst = 1'b1;
      tick();
      compared++;
      if (gnt !== 16'h0 || mux_en !== 1'b0 || busy !== 1'b0 || smp_valid !== 1'b0 ||
          mux_sel !== 4'd0 || smp_src !== 4'd0) begin
         mismatched++;
         $display("FAIL rstmid_abort: gnt=%h en=%b busy=%b vld=%b sel=%0d src=%0d, want all 0",
                  gnt, mux_en, busy, smp_valid, mux_sel, smp_src);
      end
      rst = 1'b0;
      wait_valid(12, w, s);
      compared++;
      if (!s || w != HOLD + 2 || smp_src !== 4'd0) begin
         mismatched++;
         $display("FAIL rstmid_priority: seen=%b gap=%0d src=%0d, want gap=%0d src=0", s, w, smp_src, HOLD + 2);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_random;
      int          ptr = 15;
      bit          idle = 1'b1;
      int          src = 0;
      int          last_sel = 0;
      int          due = 0;
      logic [15:0] r = '0;
      do_reset();
      pattern = 16'($urandom);
      for (int t = 0; t < 400; t++) begin
         if (!idle && t == due) begin
            compared++;
            if (smp_valid !== 1'b1 || smp_src !== 4'(src) || smp_data !== pattern[src] ||
                mux_en !== 1'b0 || gnt !== 16'h0) begin
               mismatched++;
               $display("FAIL rand_sample t=%0d: vld=%b src=%0d data=%b en=%b gnt=%h, want 1 %0d %b 0 0000",
                        t, smp_valid, smp_src, smp_data, mux_en, gnt, src, pattern[src]);
            end
            ptr = src;
            idle = 1'b1;
            r[src] = 1'b0;
         end else if (!idle) begin
            compared++;
            if (smp_valid !== 1'b0 || mux_en !== 1'b1 || busy !== 1'b1 ||
                mux_sel !== 4'(src) || gnt !== (16'd1 << src)) begin
               mismatched++;
               $display("FAIL rand_active t=%0d: vld=%b en=%b busy=%b sel=%0d gnt=%h, want 0 1 1 %0d",
                        t, smp_valid, mux_en, busy, mux_sel, gnt, src);
            end
         end else begin
            compared++;
            if (smp_valid !== 1'b0 || mux_en !== 1'b0 || busy !== 1'b0 ||
                gnt !== 16'h0 || mux_sel !== 4'(last_sel)) begin
               mismatched++;
               $display("FAIL rand_idle t=%0d: vld=%b en=%b busy=%b gnt=%h sel=%0d, want 0 0 0 0000 %0d",
                        t, smp_valid, mux_en, busy, gnt, mux_sel, last_sel);
            end
         end
         if ($urandom_range(0, 2) == 0) r = r | (16'd1 << $urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) r = 16'($urandom);
         req = r;
         if (idle && r != 16'h0) begin
            src = ref_pick(r, ptr);
            last_sel = src;
            due = t + HOLD + 2;
            idle = 1'b0;
         end
         tick();
      end
      req = '0;
      for (int i = 0; i < 6; i++) tick();
   endtask

`ifdef MUX_RR_SEQUENCER_LOCK_EN
   task automatic test_lock;
      int w;
      bit s;
      do_reset();
      lock = 1'b1;
      req = 16'h0008;
      wait_valid(12, w, s);
      compared++;
      if (!s || w != HOLD + 2 || smp_src !== 4'd3) begin
         mismatched++;
         $display("FAIL lock_first: seen=%b gap=%0d src=%0d, want gap=%0d src=3", s, w, smp_src, HOLD + 2);
      end
      for (int n = 0; n < 3; n++) begin
         wait_valid(12, w, s);
         compared++;
         if (!s || w != HOLD + 1 || smp_src !== 4'd3 || mux_en !== 1'b1 || gnt !== 16'h0008) begin
            mismatched++;
            $display("FAIL lock_repeat n=%0d: seen=%b gap=%0d src=%0d en=%b gnt=%h, want gap=%0d src=3 en=1 gnt=0008",
                     n, s, w, smp_src, mux_en, gnt, HOLD + 1);
         end
      end
      lock = 1'b0;
      wait_valid(12, w, s);
      compared++;
      if (!s || w != HOLD + 1 || smp_src !== 4'd3 || mux_en !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL lock_release: seen=%b gap=%0d src=%0d en=%b busy=%b, want gap=%0d src=3 en=0 busy=0",
                  s, w, smp_src, mux_en, busy, HOLD + 1);
      end
      req = 16'h0011;
      wait_valid(12, w, s);
      compared++;
      if (!s || smp_src !== 4'd4) begin
         mismatched++;
         $display("FAIL lock_ptr: seen=%b src=%0d, want 4 (rr_ptr=3 after release)", s, smp_src);
      end
      req = '0;
      tick();
      tick();
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_full_load();
      test_wrap();
      test_req_drop();
      test_reset_mid();
      test_random();
`ifdef MUX_RR_SEQUENCER_LOCK_EN
      test_lock();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
